// File: rtl/trace_pkg.sv
// Shared definitions for the retire-trace emitter: event codes, the
// buffered slot record and the serializer state encoding.
package trace_pkg;

    typedef enum logic [1:0] {
        EV_REG   = 2'd0,
        EV_LOAD  = 2'd1,
        EV_STORE = 2'd2,
        EV_HALT  = 2'd3
    } ev_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // One retire slot. The HALT data field is not stored: the instruction
    // counter freezes once a halt slot is captured, so it is read live at
    // emission time. Memory data holds rdata or wdata, selected by mem_wr.
    typedef struct packed {
        logic        reg_v;
        logic        mem_v;
        logic        mem_wr;
        logic        halt_v;
        logic [2:0]  reg_num;
        logic [15:0] reg_data;
        logic [15:0] mem_addr;
        logic [15:0] mem_data;
        logic [15:0] halt_cycle;
    } slot_t;

    localparam int SLOT_W = $bits(slot_t);

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO for retire slots. A push while full is accepted only
// when a pop happens in the same cycle.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Slot storage write port.
    // NOTE: the storage array has no reset; the pointers and count define
    // which entries are meaningful, and leaving it unreset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/trace_emitter.sv
// Retire-trace emitter: captures retire slots, buffers them and serializes
// each slot into REG / LOAD-STORE / HALT event words over a valid/ready port.
module trace_emitter
    import trace_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_wr_en,
    input  logic [2:0]  reg_wr_num,
    input  logic [15:0] reg_wr_data,
    input  logic        mem_en,
    input  logic        mem_wr,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_type,
    output logic [15:0] out_addr,
    output logic [15:0] out_data,
    output logic        overflow,
    output logic        done
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e            state, state_nx;
    logic              reg_sent, reg_sent_nx;
    logic              mem_sent, mem_sent_nx;
    logic [31:0]       cycle_count;
    logic [31:0]       inst_count;
    logic              halt_seen;
    slot_t             slot_in;
    slot_t             head;
    logic [SLOT_W-1:0] head_bits;
    logic              full, empty;
    logic [CW-1:0]     count;
    logic              slot_form, push, pop, fire;
    ev_type_e          cur_type;
    logic [15:0]       cur_addr, cur_data;
    logic              cur_last;

    assign slot_form = (reg_wr_en | mem_en | halt) & ~halt_seen;
    assign push      = slot_form & (~full | pop);
    assign out_valid = (state == ST_EMIT);
    assign fire      = out_valid & out_ready;
    assign pop       = fire & cur_last;
    assign done      = (state == ST_DONE);
    assign out_type  = out_valid ? cur_type : EV_REG;
    assign out_addr  = out_valid ? cur_addr : 16'h0000;
    assign out_data  = out_valid ? cur_data : 16'h0000;
    assign head      = slot_t'(head_bits);

    // Pack the current retire inputs into a slot record.
    // NOTE: every combinational output gets a default first so no path
    // leaves a value unassigned and infers a latch.
    always_comb begin
        slot_in            = '0;
        slot_in.reg_v      = reg_wr_en;
        slot_in.mem_v      = mem_en;
        slot_in.mem_wr     = mem_wr;
        slot_in.halt_v     = halt;
        slot_in.reg_num    = reg_wr_num;
        slot_in.reg_data   = reg_wr_data;
        slot_in.mem_addr   = mem_addr;
        slot_in.mem_data   = mem_wr ? mem_wdata : mem_rdata;
        slot_in.halt_cycle = cycle_count[15:0];
    end

    trace_fifo #(
        .WIDTH (SLOT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (slot_in),
        .pop   (pop),
        .dout  (head_bits),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Pick the first not-yet-sent event of the head slot.
    always_comb begin
        cur_type = EV_REG;
        cur_addr = 16'h0000;
        cur_data = 16'h0000;
        cur_last = 1'b1;
        if (head.reg_v && !reg_sent) begin
            cur_type = EV_REG;
            cur_addr = {13'b0, head.reg_num};
            cur_data = head.reg_data;
            cur_last = ~head.mem_v & ~head.halt_v;
        end else if (head.mem_v && !mem_sent) begin
            cur_type = head.mem_wr ? EV_STORE : EV_LOAD;
            cur_addr = head.mem_addr;
            cur_data = head.mem_data;
            cur_last = ~head.halt_v;
        end else begin
            cur_type = EV_HALT;
            cur_addr = head.halt_cycle;
            cur_data = inst_count[15:0];
            cur_last = 1'b1;
        end
    end

    // Serializer next-state: advance through the head slot on transfers.
    always_comb begin
        state_nx    = state;
        reg_sent_nx = reg_sent;
        mem_sent_nx = mem_sent;
        case (state)
            ST_IDLE: begin
                if (push || !empty) state_nx = ST_EMIT;
            end
            ST_EMIT: begin
                if (fire) begin
                    if (cur_last) begin
                        reg_sent_nx = 1'b0;
                        mem_sent_nx = 1'b0;
                        if (cur_type == EV_HALT)              state_nx = ST_DONE;
                        else if (count > CW'(1) || push)      state_nx = ST_EMIT;
                        else                                  state_nx = ST_IDLE;
                    end else if (cur_type == EV_REG) begin
                        reg_sent_nx = 1'b1;
                    end else begin
                        mem_sent_nx = 1'b1;
                    end
                end
            end
            ST_DONE: state_nx = ST_DONE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Serializer state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            reg_sent <= 1'b0;
            mem_sent <= 1'b0;
        end else begin
            state    <= state_nx;
            reg_sent <= reg_sent_nx;
            mem_sent <= mem_sent_nx;
        end
    end

    // Cycle / instruction counters, halt capture flag and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_count <= '0;
            inst_count  <= '0;
            halt_seen   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            if (!halt_seen && (halt || reg_wr_en || (mem_en && mem_wr)))
                inst_count <= inst_count + 32'd1;
            if (push && halt)
                halt_seen <= 1'b1;
            if (slot_form && full && !pop)
                overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_trace_emitter.sv
// Self-checking bench for trace_emitter: an event-queue model checked every
// cycle plus directed scenarios with hand-computed literal expectations.
module tb_trace_emitter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_wr_en;
    logic [2:0]  reg_wr_num;
    logic [15:0] reg_wr_data;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        halt;
    logic        out_valid, out_ready;
    logic [1:0]  out_type;
    logic [15:0] out_addr, out_data;
    logic        overflow, done;

    int checks   = 0;
    int failures = 0;
    int xfers    = 0;
    int x0;

    trace_emitter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_num  (reg_wr_num),
        .reg_wr_data (reg_wr_data),
        .mem_en      (mem_en),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .halt        (halt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_type    (out_type),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .overflow    (overflow),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: a flat queue of pending events ----
    typedef struct {
        logic [1:0]  t;
        logic [15:0] a;
        logic [15:0] d;
        bit          last;
    } ev_t;

    ev_t         q[$];
    ev_t         e;
    logic [31:0] m_cyc;
    logic [31:0] m_inst;
    bit          m_halted, m_done, m_ovf, model_live = 0;
    bit          m_popped;
    int          held;

    // Slots still buffered = events in the queue that close a slot.
    function automatic int slots_held();
        int n = 0;
        foreach (q[i]) if (q[i].last) n++;
        return n;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            q.delete();
            m_cyc = 0; m_inst = 0;
            m_halted = 0; m_done = 0; m_ovf = 0;
            model_live = 1;
        end else if (model_live) begin
            m_popped = 0;
            if (q.size() != 0 && out_ready) begin
                e = q.pop_front();
                m_popped = e.last;
                if (e.t == 2'd3) m_done = 1;
            end
            if (!m_halted && (halt || reg_wr_en || (mem_en && mem_wr)))
                m_inst = m_inst + 1;
            if (!m_halted && (reg_wr_en || mem_en || halt)) begin
                held = slots_held();
                if (held < DEPTH) begin
                    if (reg_wr_en) begin
                        e.t = 2'd0; e.a = {13'b0, reg_wr_num}; e.d = reg_wr_data;
                        e.last = !(mem_en || halt);
                        q.push_back(e);
                    end
                    if (mem_en) begin
                        e.t = mem_wr ? 2'd2 : 2'd1; e.a = mem_addr;
                        e.d = mem_wr ? mem_wdata : mem_rdata;
                        e.last = !halt;
                        q.push_back(e);
                    end
                    if (halt) begin
                        e.t = 2'd3; e.a = m_cyc[15:0]; e.d = m_inst[15:0]; e.last = 1;
                        q.push_back(e);
                        m_halted = 1;
                    end
                end else begin
                    m_ovf = 1;
                end
            end
            m_cyc = m_cyc + 1;
        end
    end

    // Compare DUT outputs with the model mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (model_live) begin
            check("cmp_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
            if (q.size() != 0) begin
                check("cmp_type", {30'b0, out_type}, {30'b0, q[0].t});
                check("cmp_addr", {16'b0, out_addr}, {16'b0, q[0].a});
                check("cmp_data", {16'b0, out_data}, {16'b0, q[0].d});
            end
            check("cmp_overflow", {31'b0, overflow}, {31'b0, m_ovf});
            check("cmp_done", {31'b0, done}, {31'b0, m_done});
            if (rst && out_valid && out_ready) xfers++;
        end
    end

    // ---------------- stimulus helpers ---------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        reg_wr_en = 0; reg_wr_num = 0; reg_wr_data = 0;
        mem_en = 0; mem_wr = 0; mem_addr = 0; mem_wdata = 0; mem_rdata = 0;
        halt = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        clear_in();
        tick();
        rst = 1;
    endtask

    task automatic set_reg(input logic [2:0] n, input logic [15:0] d);
        reg_wr_en = 1; reg_wr_num = n; reg_wr_data = d;
    endtask

    task automatic expect_ev(input string name, input logic [1:0] t,
                             input logic [15:0] a, input logic [15:0] d);
        check({name, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({name, "_type"},  {30'b0, out_type}, {30'b0, t});
        check({name, "_addr"},  {16'b0, out_addr}, {16'b0, a});
        check({name, "_data"},  {16'b0, out_data}, {16'b0, d});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0; out_ready = 1; clear_in();

        // Reset state, then a single REG slot and a following halt slot.
        tick(); tick();
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_type",  {30'b0, out_type}, 32'd0);
        check("rst_addr",  {16'b0, out_addr}, 32'd0);
        check("rst_data",  {16'b0, out_data}, 32'd0);
        check("rst_ovf",   {31'b0, overflow}, 32'd0);
        check("rst_done",  {31'b0, done}, 32'd0);
        rst = 1;
        set_reg(3'd3, 16'h00AB); tick(); clear_in();
        expect_ev("single_reg", 2'd0, 16'h0003, 16'h00AB);
        halt = 1; tick(); clear_in();
        // halt cycle is the 2nd non-reset cycle (cycle_count 1); inst 2
        expect_ev("halt_after_reg", 2'd3, 16'h0001, 16'h0002);
        tick();
        check("done_set", {31'b0, done}, 32'd1);
        set_reg(3'd1, 16'hFFFF); tick(); clear_in(); tick();
        check("done_ignores", {31'b0, out_valid}, 32'd0);

        // REG + LOAD + HALT in one slot.
        do_reset();
        set_reg(3'd1, 16'h1234);
        mem_en = 1; mem_wr = 0; mem_addr = 16'h0040; mem_rdata = 16'hBEEF; mem_wdata = 16'h1111;
        halt = 1;
        tick(); clear_in();
        expect_ev("s3_reg", 2'd0, 16'h0001, 16'h1234);
        tick();
        expect_ev("s3_load", 2'd1, 16'h0040, 16'hBEEF);
        tick();
        expect_ev("s3_halt", 2'd3, 16'h0000, 16'h0001);
        tick();
        check("s3_done", {31'b0, done}, 32'd1);
        check("s3_idle", {31'b0, out_valid}, 32'd0);

        // Stall with 6 slots into a 4-deep FIFO: two dropped.
        do_reset();
        out_ready = 0;
        for (int i = 0; i < 6; i++) begin
            set_reg(3'(i), 16'h0100 + 16'(i)); tick(); clear_in();
        end
        repeat (4) tick();
        check("ovf_set", {31'b0, overflow}, 32'd1);
        expect_ev("ovf_head", 2'd0, 16'h0000, 16'h0100);
        x0 = xfers;
        out_ready = 1;
        repeat (8) tick();
        check("ovf_drain_count", 32'(xfers - x0), 32'd4);
        check("ovf_drained", {31'b0, out_valid}, 32'd0);

        // Full FIFO, pop and push in the same cycle.
        do_reset();
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            set_reg(3'(i), 16'h0200 + 16'(i)); tick(); clear_in();
        end
        check("full_no_ovf", {31'b0, overflow}, 32'd0);
        x0 = xfers;
        out_ready = 1;
        mem_en = 1; mem_wr = 1; mem_addr = 16'h0010; mem_wdata = 16'h5555; mem_rdata = 16'hDEAD;
        tick(); clear_in();
        check("pushpop_no_ovf", {31'b0, overflow}, 32'd0);
        repeat (6) tick();
        check("pushpop_count", 32'(xfers - x0), 32'd5);

        // Back-pressure during a two-event slot.
        do_reset();
        out_ready = 1;
        set_reg(3'd5, 16'h0505);
        mem_en = 1; mem_wr = 1; mem_addr = 16'h0020; mem_wdata = 16'h7777;
        x0 = xfers;
        tick(); clear_in();
        expect_ev("bp_reg", 2'd0, 16'h0005, 16'h0505);
        tick();
        expect_ev("bp_store", 2'd2, 16'h0020, 16'h7777);
        out_ready = 0;
        tick();
        expect_ev("bp_hold1", 2'd2, 16'h0020, 16'h7777);
        tick();
        expect_ev("bp_hold2", 2'd2, 16'h0020, 16'h7777);
        out_ready = 1;
        tick();
        check("bp_empty", {31'b0, out_valid}, 32'd0);
        check("bp_count", 32'(xfers - x0), 32'd2);

        // Reset while emitting with three slots buffered.
        do_reset();
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            set_reg(3'(i), 16'h0300 + 16'(i)); tick(); clear_in();
        end
        check("mid_emit", {31'b0, out_valid}, 32'd1);
        rst = 0; tick(); rst = 1;
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_ovf", {31'b0, overflow}, 32'd0);
        check("mid_rst_done", {31'b0, done}, 32'd0);
        out_ready = 1;
        set_reg(3'd2, 16'h2222); halt = 1; tick(); clear_in();
        expect_ev("post_rst_reg", 2'd0, 16'h0002, 16'h2222);
        tick();
        expect_ev("post_rst_halt", 2'd3, 16'h0000, 16'h0001);
        tick();
        check("post_rst_done", {31'b0, done}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trace_emitter.md
TRACE_EMITTER -- requirements
Module: trace_emitter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of buffered retire slots (power of 2, min 2).
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-004 reg_wr_en  in  1  writeback writes the register file this cycle; reg_wr_num  in  3  destination register; reg_wr_data  in  16  write data.
REQ-005 mem_en  in  1  memory access this cycle; mem_wr  in  1  1 = store, 0 = load; mem_addr  in  16  address; mem_wdata  in  16  store data; mem_rdata  in  16  load data.
REQ-006 halt  in  1  halt retired this cycle.
REQ-007 out_valid  out  1  event word valid; out_ready  in  1  consumer accepts; out_type  out  2  event type; out_addr  out  16  event address field; out_data  out  16  event data field.
REQ-008 overflow  out  1  sticky, a retire slot was dropped; done  out  1  HALT event accepted, block idle.

Function
REQ-009 Event types SHALL be REG=0, LOAD=1, STORE=2, HALT=3.
REQ-010 Each non-reset cycle with (reg_wr_en | mem_en | halt) = 1 and done = 0 SHALL form one retire slot; cycles with all three 0 form no slot.
REQ-011 A slot SHALL expand into events in fixed order REG, LOAD/STORE, HALT, omitting absent events (1 to 3 events per slot).
REQ-012 REG event: addr = {13'b0, reg_wr_num}, data = reg_wr_data.
REQ-013 LOAD event (mem_en & ~mem_wr): addr = mem_addr, data = mem_rdata; STORE event (mem_en & mem_wr): addr = mem_addr, data = mem_wdata.
REQ-014 HALT event: addr = cycle_count[15:0], data = inst_count[15:0], both sampled in the halt cycle, inst_count including that cycle's slot.
REQ-015 cycle_count SHALL be 32 bits, 0 after reset, +1 every non-reset cycle, wrapping modulo 2^32.
REQ-016 inst_count SHALL be 32 bits, 0 after reset, +1 in every non-reset cycle with (halt | reg_wr_en | (mem_en & mem_wr)) and done = 0, wrapping.
REQ-017 Slots SHALL enter a FIFO_DEPTH-entry FIFO; earliest out_valid for a slot is the cycle after capture (latency 1).
REQ-018 Handshake: an event transfers on rising clk with out_valid & out_ready; once out_valid rises, out_type/out_addr/out_data SHALL hold until transfer.
REQ-019 The head slot SHALL be popped in the cycle its last event transfers; the next slot's first event may be valid in the following cycle.
REQ-020 Serializer FSM states: IDLE (FIFO empty, out_valid=0), EMIT (presenting pending event of head slot), DONE (HALT transferred); IDLE->EMIT on non-empty; EMIT->EMIT/IDLE on last-event transfer by FIFO occupancy; EMIT->DONE on HALT transfer.
REQ-021 Full FIFO with a pop in the same cycle SHALL accept the new slot; full without a pop SHALL drop it and set overflow (held until reset).
REQ-022 After a halt slot is captured, later slots SHALL be ignored (not counted, not enqueued, no overflow).
REQ-023 In DONE, done = 1, out_valid = 0, cycle_count continues; only reset leaves DONE.

Reset
REQ-024 With rst = 0 at a rising edge: FIFO emptied, FSM to IDLE, counters 0, out_valid=0, out_type=0, out_addr=0, out_data=0, overflow=0, done=0.
REQ-025 Reset mid-transfer SHALL discard all buffered and partially emitted slots; no event is emitted after reset until a new slot is captured.
REQ-026 Inputs in reset cycles SHALL not form slots or change counters.

Structure
REQ-027 Event-type codes, slot record layout (valid bits + fields, 71 bits) and FSM state encodings SHALL live in a shared package trace_pkg.
REQ-028 The slot FIFO SHALL be a sub-module trace_fifo (parameterised width/depth, push/pop/full/empty); serializer FSM and counters stay in trace_emitter.

Verification
REQ-029 Reset, then cycle 1 reg_wr_en=1 num=3 data=0x00AB, out_ready=1 -> cycle 2 one REG event addr=0x0003 data=0x00AB; inst_count=1.
REQ-030 One slot with reg write (r1=0x1234), load (addr 0x0040, rdata 0xBEEF) and halt, out_ready=1 -> three consecutive events REG, LOAD 0x0040/0xBEEF, HALT data=0x0001; then done=1.
REQ-031 out_ready=0 for 10 cycles while 6 single-event slots arrive with FIFO_DEPTH=4 -> first 4 retained in order, 5th/6th dropped, overflow=1; releasing out_ready yields exactly 4 events.
REQ-032 FIFO full, out_ready=1 popping a 1-event head while a new store slot (0x0010/0x5555) arrives -> slot accepted, overflow stays 0, STORE emitted in order.
REQ-033 out_ready toggled 1,0,1 during a 2-event slot -> fields stable while stalled, no duplicated or lost events.
REQ-034 rst=0 asserted while EMIT with 3 slots buffered -> next cycle out_valid=0, counters 0, overflow=0; subsequent slot emits normally.
